cpu_execute_unit: RTL and testbench

- EX stage of the 5-stage RISC-V pipeline, directly upstream of the MEM stage.
- Executes the RV32I ALU ops, branch/jump resolution, and the RV32M extension. MUL* completes in 1 cycle; DIV/REM run on an iterative divider.
- Produces the ALU result or memory address, the store data and the MEM-stage control word.
- Uses the same ready-based pipeline handshake as the MEM stage: register inputs on own ready, emit bubbles while busy.

---
 rtl/rapid_pkg.sv | 74 +++++++
 rtl/cpu_divider.sv | 134 +++++++++++++
 rtl/cpu_execute_unit.sv | 192 +++++++++++++++++++
 tb/tb_cpu_execute_unit.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rapid_pkg.sv
// Shared pipeline types for the EX stage: ALU/branch encodings, the EX and
// MEM control words, their NOP defaults and small decode helpers.
package rapid_pkg;

  localparam int XLEN = 32;

  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
    ALU_OR, ALU_AND,
    ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
    ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
  } alu_op_e;

  typedef enum logic {
    SRC_B_REG,
    SRC_B_IMM
  } src_b_e;

  typedef enum logic [3:0] {
    BR_NONE, BR_BEQ, BR_BNE, BR_BLT, BR_BGE, BR_BLTU, BR_BGEU, BR_JAL, BR_JALR
  } branch_e;

  typedef enum logic [1:0] {
    EX_IDLE,
    EX_DIVIDE,
    EX_DONE
  } ex_state_e;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] mem_size;
    logic       mem_unsigned;
    logic [4:0] rd;
  } control_mem_s;

  typedef struct packed {
    alu_op_e      alu_op;
    src_b_e       src_b;
    branch_e      branch;
    control_mem_s mem_ctl;
  } control_ex_s;

  // Bubble control word for MEM: nothing read, written or retired.
  function automatic control_mem_s control_mem_s_default();
    control_mem_s c;
    c = '0;
    return c;
  endfunction

  // NOP for EX: ADD x0-style with a bubble memory control word.
  function automatic control_ex_s control_ex_s_default();
    control_ex_s c;
    c.alu_op  = ALU_ADD;
    c.src_b   = SRC_B_REG;
    c.branch  = BR_NONE;
    c.mem_ctl = control_mem_s_default();
    return c;
  endfunction

  function automatic logic is_div_op(alu_op_e op);
    return op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
  endfunction

  function automatic logic is_rem_op(alu_op_e op);
    return op inside {ALU_REM, ALU_REMU};
  endfunction

  function automatic logic is_signed_div_op(alu_op_e op);
    return op inside {ALU_DIV, ALU_REM};
  endfunction

endpackage

// File: rtl/cpu_divider.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU. Signed operands
// are divided as magnitudes and the signs fixed up on the way out. Divide
// by zero and signed overflow are resolved at start and report done in the
// first busy cycle without iterating.
module cpu_divider
  import rapid_pkg::*;
#(
  parameter int DIV_BITS_PER_CYCLE = 1
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_start,
  input  logic            i_signed,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  output logic            o_done,
  output logic [XLEN-1:0] o_quotient,
  output logic [XLEN-1:0] o_remainder
);

  localparam int STEPS = XLEN / DIV_BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(STEPS + 1);

  logic             busy_q, busy_d;
  logic             special_q, special_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  rem_q, rem_d;
  logic [XLEN-1:0]  quo_q, quo_d;
  logic [XLEN-1:0]  dsr_q, dsr_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;

  logic [XLEN-1:0]  step_rem, step_quo;
  logic [XLEN+1:0]  div_shift, div_trial;
  logic [XLEN-1:0]  dividend_mag, divisor_mag;

  // One cycle of restoring iterations on the current partial remainder.
  always_comb begin
    // NOTE: every signal written here gets a value before any branch or loop, so no latch can be inferred.
    step_rem  = rem_q;
    step_quo  = quo_q;
    div_shift = '0;
    div_trial = '0;
    for (int i = 0; i < DIV_BITS_PER_CYCLE; i++) begin
      div_shift = {1'b0, step_rem, step_quo[XLEN-1]};
      div_trial = div_shift - {2'b00, dsr_q};
      if (div_trial[XLEN+1]) begin
        step_rem = div_shift[XLEN-1:0];
      end else begin
        step_rem = div_trial[XLEN-1:0];
      end
      step_quo = {step_quo[XLEN-2:0], ~div_trial[XLEN+1]};
    end
  end

  // Done flag and sign-corrected results, valid while o_done is high.
  always_comb begin
    o_done      = busy_q && (special_q || (cnt_q == CNT_W'(1)));
    o_quotient  = quo_q;
    o_remainder = rem_q;
    if (!special_q) begin
      o_quotient  = neg_quo_q ? -step_quo : step_quo;
      o_remainder = neg_rem_q ? -step_rem : step_rem;
    end
  end

  // Operand setup on start, then iterate until the counter runs out.
  always_comb begin
    dividend_mag = (i_signed && i_dividend[XLEN-1]) ? -i_dividend : i_dividend;
    divisor_mag  = (i_signed && i_divisor[XLEN-1])  ? -i_divisor  : i_divisor;
    busy_d    = busy_q;
    special_d = special_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dsr_d     = dsr_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    if (i_start) begin
      busy_d    = 1'b1;
      cnt_d     = CNT_W'(STEPS);
      dsr_d     = divisor_mag;
      neg_quo_d = i_signed && (i_dividend[XLEN-1] ^ i_divisor[XLEN-1]);
      neg_rem_d = i_signed && i_dividend[XLEN-1];
      if (i_divisor == '0) begin
        special_d = 1'b1;
        quo_d     = '1;
        rem_d     = i_dividend;
      end else if (i_signed && (i_dividend == 32'h8000_0000) && (i_divisor == '1)) begin
        special_d = 1'b1;
        quo_d     = 32'h8000_0000;
        rem_d     = '0;
      end else begin
        special_d = 1'b0;
        quo_d     = dividend_mag;
        rem_d     = '0;
      end
    end else if (busy_q) begin
      if (o_done) begin
        busy_d    = 1'b0;
        special_d = 1'b0;
      end else begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  // Divider state registers; reset aborts any divide in flight.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      busy_q    <= 1'b0;
      special_q <= 1'b0;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dsr_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      busy_q    <= busy_d;
      special_q <= special_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dsr_q     <= dsr_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

endmodule

// File: rtl/cpu_execute_unit.sv
// EX stage of the 5-stage RV32IM pipeline. Registers the decoded instruction
// when ready, computes ALU/MUL results, addresses, jump links and branch
// redirects combinationally, and runs DIV/REM through cpu_divider while
// emitting bubbles to MEM.
module cpu_execute_unit
  import rapid_pkg::*;
#(
  parameter int DIV_BITS_PER_CYCLE = 1
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  control_ex_s     i_control_sig,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic [XLEN-1:0] i_imm,
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_mem_ready,
  output logic [XLEN-1:0] o_data_out,
  output logic [XLEN-1:0] o_rs2,
  output control_mem_s    o_control_mem,
  output logic            o_branch_taken,
  output logic [XLEN-1:0] o_branch_target,
  output logic            o_pipeline_ready
);

  control_ex_s     ir_control_sig_q, ir_control_sig_d;
  logic [XLEN-1:0] ir_rs1_q, ir_rs1_d;
  logic [XLEN-1:0] ir_rs2_q, ir_rs2_d;
  logic [XLEN-1:0] ir_imm_q, ir_imm_d;
  logic [XLEN-1:0] ir_pc_q, ir_pc_d;
  logic [XLEN-1:0] r_div_result_q, r_div_result_d;
  ex_state_e       state_q, state_d;

  alu_op_e         op;
  logic [XLEN-1:0] operand_b;
  logic [4:0]      shamt;
  logic [XLEN-1:0] alu_result;
  logic [XLEN:0]   mul_a, mul_b;
  logic [63:0]     mul_a_ext, mul_b_ext, mul_prod;
  logic            branch_cond, is_jump, is_cond_branch;
  logic [XLEN-1:0] jump_link;
  logic            div_start, div_done;
  logic [XLEN-1:0] div_quotient, div_remainder;

  assign op = ir_control_sig_q.alu_op;

  // Input registers follow the inputs only in cycles where EX accepts.
  always_comb begin
    ir_control_sig_d = ir_control_sig_q;
    ir_rs1_d         = ir_rs1_q;
    ir_rs2_d         = ir_rs2_q;
    ir_imm_d         = ir_imm_q;
    ir_pc_d          = ir_pc_q;
    if (o_pipeline_ready) begin
      ir_control_sig_d = i_control_sig;
      ir_rs1_d         = i_rs1;
      ir_rs2_d         = i_rs2;
      ir_imm_d         = i_imm;
      ir_pc_d          = i_pc;
    end
  end

  // Single-cycle ALU and multiplier on the registered operands.
  always_comb begin
    operand_b = (ir_control_sig_q.src_b == SRC_B_IMM) ? ir_imm_q : ir_rs2_q;
    shamt     = operand_b[4:0];
    // 33-bit operands: the extra top bit is the sign for signed inputs, 0 otherwise.
    mul_a     = {(op == ALU_MULH || op == ALU_MULHSU) && ir_rs1_q[XLEN-1], ir_rs1_q};
    mul_b     = {(op == ALU_MULH) && operand_b[XLEN-1], operand_b};
    mul_a_ext = {{(63 - XLEN){mul_a[XLEN]}}, mul_a};
    mul_b_ext = {{(63 - XLEN){mul_b[XLEN]}}, mul_b};
    mul_prod  = mul_a_ext * mul_b_ext;
    case (op)
      ALU_ADD:    alu_result = ir_rs1_q + operand_b;
      ALU_SUB:    alu_result = ir_rs1_q - operand_b;
      ALU_SLL:    alu_result = ir_rs1_q << shamt;
      ALU_SLT:    alu_result = {31'b0, $signed(ir_rs1_q) < $signed(operand_b)};
      ALU_SLTU:   alu_result = {31'b0, ir_rs1_q < operand_b};
      ALU_XOR:    alu_result = ir_rs1_q ^ operand_b;
      ALU_SRL:    alu_result = ir_rs1_q >> shamt;
      ALU_SRA:    alu_result = $unsigned($signed(ir_rs1_q) >>> shamt);
      ALU_OR:     alu_result = ir_rs1_q | operand_b;
      ALU_AND:    alu_result = ir_rs1_q & operand_b;
      ALU_MUL:    alu_result = mul_prod[XLEN-1:0];
      ALU_MULH,
      ALU_MULHSU,
      ALU_MULHU:  alu_result = mul_prod[2*XLEN-1:XLEN];
      default:    alu_result = '0;
    endcase
  end

  // Branch condition and redirect target from the registered operands.
  always_comb begin
    is_jump        = ir_control_sig_q.branch inside {BR_JAL, BR_JALR};
    is_cond_branch = (ir_control_sig_q.branch != BR_NONE) && !is_jump;
    jump_link      = ir_pc_q + 32'd4;
    case (ir_control_sig_q.branch)
      BR_BEQ:  branch_cond = (ir_rs1_q == ir_rs2_q);
      BR_BNE:  branch_cond = (ir_rs1_q != ir_rs2_q);
      BR_BLT:  branch_cond = ($signed(ir_rs1_q) < $signed(ir_rs2_q));
      BR_BGE:  branch_cond = ($signed(ir_rs1_q) >= $signed(ir_rs2_q));
      BR_BLTU: branch_cond = (ir_rs1_q < ir_rs2_q);
      BR_BGEU: branch_cond = (ir_rs1_q >= ir_rs2_q);
      BR_JAL,
      BR_JALR: branch_cond = 1'b1;
      default: branch_cond = 1'b0;
    endcase
    if (ir_control_sig_q.branch == BR_JALR) begin
      o_branch_target = (ir_rs1_q + ir_imm_q) & ~32'd1;
    end else begin
      o_branch_target = ir_pc_q + ir_imm_q;
    end
  end

  assign o_rs2 = ir_rs2_q;

  // Sequencer: single-cycle ops in IDLE, divides park in DIVIDE then DONE.
  always_comb begin
    state_d          = state_q;
    r_div_result_d   = r_div_result_q;
    div_start        = 1'b0;
    o_pipeline_ready = i_mem_ready;
    o_data_out       = '0;
    o_control_mem    = control_mem_s_default();
    o_branch_taken   = 1'b0;
    case (state_q)
      EX_IDLE: begin
        if (is_div_op(op)) begin
          div_start        = 1'b1;
          o_pipeline_ready = 1'b0;
          state_d          = EX_DIVIDE;
        end else begin
          o_data_out     = is_jump ? jump_link : alu_result;
          o_control_mem  = is_cond_branch ? control_mem_s_default() : ir_control_sig_q.mem_ctl;
          // Pulse only on the hand-over cycle so a stalled branch redirects once.
          o_branch_taken = branch_cond && i_mem_ready;
        end
      end
      EX_DIVIDE: begin
        o_pipeline_ready = 1'b0;
        if (div_done) begin
          r_div_result_d = is_rem_op(op) ? div_remainder : div_quotient;
          state_d        = EX_DONE;
        end
      end
      EX_DONE: begin
        o_data_out    = r_div_result_q;
        o_control_mem = ir_control_sig_q.mem_ctl;
        if (i_mem_ready) begin
          state_d = EX_IDLE;
        end
      end
      default: state_d = EX_IDLE;
    endcase
  end

  // Pipeline, result and state registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ir_control_sig_q <= control_ex_s_default();
      ir_rs1_q         <= '0;
      ir_rs2_q         <= '0;
      ir_imm_q         <= '0;
      ir_pc_q          <= '0;
      r_div_result_q   <= '0;
      state_q          <= EX_IDLE;
    end else begin
      ir_control_sig_q <= ir_control_sig_d;
      ir_rs1_q         <= ir_rs1_d;
      ir_rs2_q         <= ir_rs2_d;
      ir_imm_q         <= ir_imm_d;
      ir_pc_q          <= ir_pc_d;
      r_div_result_q   <= r_div_result_d;
      state_q          <= state_d;
    end
  end

  cpu_divider #(
    .DIV_BITS_PER_CYCLE (DIV_BITS_PER_CYCLE)
  ) u_divider (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_start     (div_start),
    .i_signed    (is_signed_div_op(op)),
    .i_dividend  (ir_rs1_q),
    .i_divisor   (ir_rs2_q),
    .o_done      (div_done),
    .o_quotient  (div_quotient),
    .o_remainder (div_remainder)
  );

endmodule

// File: tb/tb_cpu_execute_unit.sv
// Bench for cpu_execute_unit: directed vector table, random single-cycle ops
// against a plain-arithmetic reference, divide latency/corner sequences,
// branch stall and reset-during-divide sequences.
module tb_cpu_execute_unit;
  import rapid_pkg::*;

  localparam int BPC     = 1;
  localparam int DIV_LAT = 32 / BPC;

  logic         i_clk = 1'b0;
  logic         i_reset;
  control_ex_s  i_control_sig;
  logic [31:0]  i_rs1, i_rs2, i_imm, i_pc;
  logic         i_mem_ready;
  logic [31:0]  o_data_out, o_rs2, o_branch_target;
  control_mem_s o_control_mem;
  logic         o_branch_taken, o_pipeline_ready;

  int n_pass   = 0;
  int n_checks = 0;

  cpu_execute_unit #(.DIV_BITS_PER_CYCLE(BPC)) dut (
    .i_clk            (i_clk),
    .i_reset          (i_reset),
    .i_control_sig    (i_control_sig),
    .i_rs1            (i_rs1),
    .i_rs2            (i_rs2),
    .i_imm            (i_imm),
    .i_pc             (i_pc),
    .i_mem_ready      (i_mem_ready),
    .o_data_out       (o_data_out),
    .o_rs2            (o_rs2),
    .o_control_mem    (o_control_mem),
    .o_branch_taken   (o_branch_taken),
    .o_branch_target  (o_branch_target),
    .o_pipeline_ready (o_pipeline_ready)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0]  data;
    logic         taken;
    logic [31:0]  target;
    control_mem_s mc;
  } exp_t;

  typedef struct {
    string       name;
    control_ex_s ctl;
    logic [31:0] rs1, rs2, imm, pc;
    logic [31:0] exp_data;
    logic        exp_taken;
    logic [31:0] exp_target;
  } vec_t;

  localparam control_mem_s MC_RD5 = '{reg_write: 1'b1, mem_read: 1'b0, mem_write: 1'b0,
                                     mem_size: 2'd2, mem_unsigned: 1'b0, rd: 5'd5};
  localparam control_mem_s MC_SW  = '{reg_write: 1'b0, mem_read: 1'b0, mem_write: 1'b1,
                                     mem_size: 2'd2, mem_unsigned: 1'b0, rd: 5'd0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    else n_pass++;
  endtask

  function automatic logic [31:0] mc_bits(input control_mem_s c);
    logic [31:0] r;
    r = '0;
    r[$bits(control_mem_s)-1:0] = c;
    return r;
  endfunction

  function automatic control_ex_s mk(input alu_op_e op, input src_b_e sb, input branch_e br,
                                     input control_mem_s mc);
    control_ex_s c;
    c.alu_op = op; c.src_b = sb; c.branch = br; c.mem_ctl = mc;
    return c;
  endfunction

  // Reference model: RV32IM semantics in 64-bit integer arithmetic.
  function automatic exp_t model(input control_ex_s c, input logic [31:0] a, input logic [31:0] rs2,
                                 input logic [31:0] imm, input logic [31:0] pc);
    exp_t e;
    logic [31:0] b;
    longint sa, sb, ua, ub, s2, u2, p;
    b  = (c.src_b == SRC_B_IMM) ? imm : rs2;
    sa = longint'($signed(a));   ua = longint'({32'b0, a});
    sb = longint'($signed(b));   ub = longint'({32'b0, b});
    s2 = longint'($signed(rs2)); u2 = longint'({32'b0, rs2});
    p  = 0;
    case (c.alu_op)
      ALU_ADD:    e.data = 32'(sa + sb);
      ALU_SUB:    e.data = 32'(sa - sb);
      ALU_SLL:    e.data = 32'(ua << b[4:0]);
      ALU_SRL:    e.data = 32'(ua >> b[4:0]);
      ALU_SRA:    e.data = 32'(sa >>> b[4:0]);
      ALU_SLT:    e.data = (sa < sb) ? 32'd1 : 32'd0;
      ALU_SLTU:   e.data = (ua < ub) ? 32'd1 : 32'd0;
      ALU_XOR:    e.data = a ^ b;
      ALU_OR:     e.data = a | b;
      ALU_AND:    e.data = a & b;
      ALU_MUL:    begin p = sa * sb; e.data = p[31:0];  end
      ALU_MULH:   begin p = sa * sb; e.data = p[63:32]; end
      ALU_MULHSU: begin p = sa * ub; e.data = p[63:32]; end
      ALU_MULHU:  begin p = ua * ub; e.data = p[63:32]; end
      ALU_DIV:    e.data = (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
      ALU_DIVU:   e.data = (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
      ALU_REM:    e.data = (b == 0) ? a : 32'(sa % sb);
      ALU_REMU:   e.data = (b == 0) ? a : 32'(ua % ub);
      default:    e.data = '0;
    endcase
    case (c.branch)
      BR_BEQ:  e.taken = (a == rs2);
      BR_BNE:  e.taken = (a != rs2);
      BR_BLT:  e.taken = (longint'($signed(a)) < s2);
      BR_BGE:  e.taken = (longint'($signed(a)) >= s2);
      BR_BLTU: e.taken = (ua < u2);
      BR_BGEU: e.taken = (ua >= u2);
      BR_JAL, BR_JALR: e.taken = 1'b1;
      default: e.taken = 1'b0;
    endcase
    if (c.branch == BR_JAL || c.branch == BR_JALR) e.data = pc + 32'd4;
    e.target = (c.branch == BR_JALR) ? ((a + imm) & 32'hFFFF_FFFE) : (pc + imm);
    e.mc = (c.branch != BR_NONE && c.branch != BR_JAL && c.branch != BR_JALR)
           ? control_mem_s_default() : c.mem_ctl;
    return e;
  endfunction

  // Present an instruction and let EX register it; returns 1ns after the edge.
  task automatic drive(input control_ex_s c, input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] imm, input logic [31:0] pc);
    i_control_sig = c; i_rs1 = rs1; i_rs2 = rs2; i_imm = imm; i_pc = pc;
    @(posedge i_clk); #1;
  endtask

  task automatic drive_nop();
    i_control_sig = control_ex_s_default();
    i_rs1 = '0; i_rs2 = '0; i_imm = '0; i_pc = '0;
  endtask

  // Issue a divide, count bubble cycles, check the DONE result; optional DONE stall.
  task automatic run_div(input string name, input alu_op_e op, input logic [31:0] a,
                         input logic [31:0] b, input int exp_bubbles, input int hold);
    control_ex_s c;
    exp_t e;
    int bubbles;
    logic bub_ok;
    c = mk(op, SRC_B_REG, BR_NONE, MC_RD5);
    e = model(c, a, b, 32'h0, 32'h0);
    drive(c, a, b, 32'h0, 32'h0);
    drive_nop();
    bubbles = 0;
    bub_ok  = 1'b1;
    while (!o_pipeline_ready && bubbles < 200) begin
      bubbles++;
      if (o_control_mem != control_mem_s_default() || o_branch_taken) bub_ok = 1'b0;
      @(posedge i_clk); #1;
    end
    check({name, " bubbles"}, bubbles, exp_bubbles);
    check({name, " bubble_ctl"}, 32'(bub_ok), 32'd1);
    check({name, " result"}, o_data_out, e.data);
    check({name, " ctl"}, mc_bits(o_control_mem), mc_bits(MC_RD5));
    if (hold > 0) begin
      i_mem_ready = 1'b0;
      for (int h = 0; h < hold; h++) begin
        @(posedge i_clk); #1;
        check({name, " hold_ready"}, 32'(o_pipeline_ready), 32'd0);
        check({name, " hold_data"}, o_data_out, e.data);
      end
      i_mem_ready = 1'b1;
      #1;
      check({name, " hold_release"}, 32'(o_pipeline_ready), 32'd1);
    end
    @(posedge i_clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    alu_op_e ops[14] = '{ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL,
                         ALU_SRA, ALU_OR, ALU_AND, ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU};
    alu_op_e dops[4] = '{ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    branch_e brs[8]  = '{BR_BEQ, BR_BNE, BR_BLT, BR_BGE, BR_BLTU, BR_BGEU, BR_JAL, BR_JALR};
    logic [31:0] corners[6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h5};

    // ---------------- reset state ----------------
    i_reset = 1'b1;
    i_mem_ready = 1'b0;
    drive_nop();
    #3;
    check("rst ready_follows_mem0", 32'(o_pipeline_ready), 32'd0);
    i_mem_ready = 1'b1;
    #1;
    check("rst ready_follows_mem1", 32'(o_pipeline_ready), 32'd1);
    check("rst data", o_data_out, 32'h0);
    check("rst ctl", mc_bits(o_control_mem), 32'h0);
    check("rst taken", 32'(o_branch_taken), 32'd0);
    check("rst rs2", o_rs2, 32'h0);
    @(posedge i_clk); #2;
    i_reset = 1'b0;

    // ---------------- directed vector table ----------------
    vecs.push_back('{"add_ovf", mk(ALU_ADD, SRC_B_REG, BR_NONE, MC_RD5), 32'h7FFF_FFFF, 32'h1, 32'h0, 32'h0, 32'h8000_0000, 1'b0, 32'h0});
    vecs.push_back('{"sw_addr", mk(ALU_ADD, SRC_B_IMM, BR_NONE, MC_SW), 32'h1000, 32'hDEAD_BEEF, 32'hFFFF_FFFC, 32'h0, 32'h0000_0FFC, 1'b0, 32'h0});
    vecs.push_back('{"sub", mk(ALU_SUB, SRC_B_REG, BR_NONE, MC_RD5), 32'h5, 32'h7, 32'h0, 32'h0, 32'hFFFF_FFFE, 1'b0, 32'h0});
    vecs.push_back('{"sll_shamt5", mk(ALU_SLL, SRC_B_REG, BR_NONE, MC_RD5), 32'h1, 32'h23, 32'h0, 32'h0, 32'h8, 1'b0, 32'h0});
    vecs.push_back('{"sra_imm", mk(ALU_SRA, SRC_B_IMM, BR_NONE, MC_RD5), 32'h8000_0000, 32'h0, 32'h4, 32'h0, 32'hF800_0000, 1'b0, 32'h0});
    vecs.push_back('{"srl", mk(ALU_SRL, SRC_B_REG, BR_NONE, MC_RD5), 32'h8000_0000, 32'h4, 32'h0, 32'h0, 32'h0800_0000, 1'b0, 32'h0});
    vecs.push_back('{"slt", mk(ALU_SLT, SRC_B_REG, BR_NONE, MC_RD5), 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 32'h1, 1'b0, 32'h0});
    vecs.push_back('{"sltu", mk(ALU_SLTU, SRC_B_REG, BR_NONE, MC_RD5), 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0});
    vecs.push_back('{"xor", mk(ALU_XOR, SRC_B_REG, BR_NONE, MC_RD5), 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0, 32'h0, 32'h0FF0_0FF0, 1'b0, 32'h0});
    vecs.push_back('{"mul", mk(ALU_MUL, SRC_B_REG, BR_NONE, MC_RD5), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h1, 1'b0, 32'h0});
    vecs.push_back('{"mulh", mk(ALU_MULH, SRC_B_REG, BR_NONE, MC_RD5), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0});
    vecs.push_back('{"mulhu", mk(ALU_MULHU, SRC_B_REG, BR_NONE, MC_RD5), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'hFFFF_FFFE, 1'b0, 32'h0});
    vecs.push_back('{"mulhsu", mk(ALU_MULHSU, SRC_B_REG, BR_NONE, MC_RD5), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b0, 32'h0});
    vecs.push_back('{"mulh_min", mk(ALU_MULH, SRC_B_REG, BR_NONE, MC_RD5), 32'h8000_0000, 32'h8000_0000, 32'h0, 32'h0, 32'h4000_0000, 1'b0, 32'h0});
    vecs.push_back('{"jal", mk(ALU_ADD, SRC_B_REG, BR_JAL, MC_RD5), 32'h0, 32'h0, 32'h40, 32'h200, 32'h204, 1'b1, 32'h240});
    vecs.push_back('{"jalr", mk(ALU_ADD, SRC_B_IMM, BR_JALR, MC_RD5), 32'h1000, 32'h0, 32'h5, 32'h300, 32'h304, 1'b1, 32'h1004});
    vecs.push_back('{"bne_nt", mk(ALU_ADD, SRC_B_REG, BR_BNE, MC_RD5), 32'h3, 32'h3, 32'h10, 32'h400, 32'h6, 1'b0, 32'h0});
    vecs.push_back('{"blt_t", mk(ALU_ADD, SRC_B_REG, BR_BLT, MC_RD5), 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFF0, 32'h400, 32'h0, 1'b1, 32'h3F0});
    vecs.push_back('{"bgeu_nt", mk(ALU_ADD, SRC_B_REG, BR_BGEU, MC_RD5), 32'h1, 32'hFFFF_FFFF, 32'h8, 32'h500, 32'h0, 1'b0, 32'h0});
    vecs.push_back('{"bge_t", mk(ALU_ADD, SRC_B_REG, BR_BGE, MC_RD5), 32'h1, 32'hFFFF_FFFF, 32'h8, 32'h500, 32'h0, 1'b1, 32'h508});

    foreach (vecs[i]) begin
      control_mem_s exp_mc;
      drive(vecs[i].ctl, vecs[i].rs1, vecs[i].rs2, vecs[i].imm, vecs[i].pc);
      exp_mc = (vecs[i].ctl.branch inside {BR_BEQ, BR_BNE, BR_BLT, BR_BGE, BR_BLTU, BR_BGEU})
               ? control_mem_s_default() : vecs[i].ctl.mem_ctl;
      check({vecs[i].name, " data"}, o_data_out, vecs[i].exp_data);
      check({vecs[i].name, " taken"}, 32'(o_branch_taken), 32'(vecs[i].exp_taken));
      check({vecs[i].name, " ctl"}, mc_bits(o_control_mem), mc_bits(exp_mc));
      check({vecs[i].name, " rs2"}, o_rs2, vecs[i].rs2);
      check({vecs[i].name, " ready"}, 32'(o_pipeline_ready), 32'd1);
      if (vecs[i].exp_taken) check({vecs[i].name, " target"}, o_branch_target, vecs[i].exp_target);
    end

    // ---------------- random single-cycle ops vs model ----------------
    for (int n = 0; n < 200; n++) begin
      control_ex_s c;
      control_mem_s mc;
      exp_t e;
      logic [31:0] a, b, imm, pc, held;
      mc  = control_mem_s'($urandom);
      c   = mk(ops[$urandom_range(0, 13)], src_b_e'($urandom_range(0, 1)),
               ($urandom_range(0, 9) < 3) ? brs[$urandom_range(0, 7)] : BR_NONE, mc);
      a   = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      b   = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      if ($urandom_range(0, 5) == 0) b = a;
      imm = $urandom;
      pc  = {$urandom, 2'b00} & 32'hFFFF_FFFC;
      e   = model(c, a, b, imm, pc);
      drive(c, a, b, imm, pc);
      if ($urandom_range(0, 3) == 0) begin
        i_mem_ready = 1'b0;
        #1;
        held = o_data_out;
        check("rnd stall_taken", 32'(o_branch_taken), 32'd0);
        @(posedge i_clk); #1;
        check("rnd stall_hold", o_data_out, held);
        i_mem_ready = 1'b1;
        #1;
      end
      check($sformatf("rnd%0d data", n), o_data_out, e.data);
      check($sformatf("rnd%0d taken", n), 32'(o_branch_taken), 32'(e.taken));
      check($sformatf("rnd%0d ctl", n), mc_bits(o_control_mem), mc_bits(e.mc));
      if (e.taken) check($sformatf("rnd%0d target", n), o_branch_target, e.target);
    end

    // ---------------- divides ----------------
    run_div("div_m7_2",   ALU_DIV,  32'hFFFF_FFF9, 32'h2,         1 + DIV_LAT, 2);
    run_div("rem_m7_2",   ALU_REM,  32'hFFFF_FFF9, 32'h2,         1 + DIV_LAT, 0);
    run_div("divu_by0",   ALU_DIVU, 32'h1234_5678, 32'h0,         2, 0);
    run_div("rem_by0",    ALU_REM,  32'h8765_4321, 32'h0,         2, 0);
    run_div("div_ovf",    ALU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 2, 0);
    run_div("rem_ovf",    ALU_REM,  32'h8000_0000, 32'hFFFF_FFFF, 2, 0);
    run_div("divu_max",   ALU_DIVU, 32'hFFFF_FFFF, 32'h1,         1 + DIV_LAT, 0);
    for (int n = 0; n < 10; n++) begin
      alu_op_e op;
      logic [31:0] a, b;
      int lat;
      op = dops[$urandom_range(0, 3)];
      a  = ($urandom_range(0, 2) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      b  = ($urandom_range(0, 4) == 0) ? corners[$urandom_range(0, 5)] : ($urandom >> $urandom_range(0, 28));
      lat = (b == 0 || ((op == ALU_DIV || op == ALU_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))
            ? 2 : 1 + DIV_LAT;
      run_div($sformatf("rnd_div%0d", n), op, a, b, lat, 0);
    end

    // ---------------- BEQ held by backpressure ----------------
    begin
      int pulses;
      drive(mk(ALU_ADD, SRC_B_REG, BR_BEQ, MC_RD5), 32'h5, 32'h5, 32'h20, 32'h100);
      i_mem_ready = 1'b0;
      drive_nop();
      pulses = 0;
      for (int k = 0; k < 3; k++) begin
        #1;
        if (o_branch_taken) pulses++;
        check("beq stall_ready", 32'(o_pipeline_ready), 32'd0);
        @(posedge i_clk); #1;
      end
      check("beq no_pulse_stalled", pulses, 0);
      i_mem_ready = 1'b1;
      #1;
      check("beq pulse", 32'(o_branch_taken), 32'd1);
      check("beq target", o_branch_target, 32'h120);
      check("beq ctl_bubble", mc_bits(o_control_mem), 32'h0);
      @(posedge i_clk); #1;
      check("beq pulse_once", 32'(o_branch_taken), 32'd0);
    end

    // ---------------- reset during divide ----------------
    drive(mk(ALU_DIV, SRC_B_REG, BR_NONE, MC_RD5), 32'd100, 32'd3, 32'h0, 32'h0);
    drive_nop();
    repeat (10) begin @(posedge i_clk); #1; end
    i_reset = 1'b1;
    #1;
    check("rstdiv ready", 32'(o_pipeline_ready), 32'd1);
    check("rstdiv data", o_data_out, 32'h0);
    check("rstdiv ctl", mc_bits(o_control_mem), 32'h0);
    check("rstdiv taken", 32'(o_branch_taken), 32'd0);
    @(posedge i_clk); #2;
    i_reset = 1'b0;
    drive(mk(ALU_ADD, SRC_B_REG, BR_NONE, MC_RD5), 32'd2, 32'd3, 32'h0, 32'h0);
    check("rstdiv add_data", o_data_out, 32'd5);
    check("rstdiv add_ctl", mc_bits(o_control_mem), mc_bits(MC_RD5));
    check("rstdiv add_ready", 32'(o_pipeline_ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
